// File: rtl/spu32_sram16_ctrl.sv
// Physical-side controller for an external asynchronous 16-bit SRAM.
// Takes one tagged 16-bit request at a time and drives the chip pins with programmable strobe width.
module spu32_sram16_ctrl #(
    parameter int ADDR_BITS   = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                 I_clk,
    input  logic                 I_reset,
    input  logic [3:0]           I_request,
    input  logic                 I_we,
    input  logic                 I_ub,
    input  logic                 I_lb,
    input  logic [ADDR_BITS-1:0] I_addr,
    input  logic [15:0]          I_data,
    output logic [15:0]          O_data,
    output logic [3:0]           O_ack,
    output logic                 O_stall,
    output logic [ADDR_BITS-1:0] O_sram_addr,
    output logic [15:0]          O_sram_data,
    output logic                 O_sram_data_oe,
    input  logic [15:0]          I_sram_data,
    output logic                 O_sram_ce_n,
    output logic                 O_sram_oe_n,
    output logic                 O_sram_we_n,
    output logic                 O_sram_ub_n,
    output logic                 O_sram_lb_n
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WSETUP,
        WRITE,
        WHOLD
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t                 state;
    state_t                 state_next;
    logic [3:0]             cnt;
    logic [3:0]             cnt_next;
    logic [3:0]             tag;
    logic [3:0]             tag_next;
    logic [15:0]            data_next;
    logic [3:0]             ack_next;
    logic [ADDR_BITS-1:0]   sram_addr_next;
    logic [15:0]            sram_data_next;
    logic                   sram_data_oe_next;
    logic                   ce_n_next;
    logic                   oe_n_next;
    logic                   we_n_next;
    logic                   ub_n_next;
    logic                   lb_n_next;

    assign O_stall = I_reset | (state != IDLE);

    // Next-state and pin logic; every register holds its value unless a state changes it.
    always_comb begin
        state_next        = state;
        cnt_next          = cnt;
        tag_next          = tag;
        data_next         = O_data;
        ack_next          = 4'h0;
        sram_addr_next    = O_sram_addr;
        sram_data_next    = O_sram_data;
        sram_data_oe_next = O_sram_data_oe;
        ce_n_next         = O_sram_ce_n;
        oe_n_next         = O_sram_oe_n;
        we_n_next         = O_sram_we_n;
        ub_n_next         = O_sram_ub_n;
        lb_n_next         = O_sram_lb_n;

        case (state)
            IDLE: begin
                if (I_request != 4'h0) begin
                    tag_next       = I_request;
                    sram_addr_next = I_addr;
                    sram_data_next = I_data;
                    ce_n_next      = 1'b0;
                    ub_n_next      = ~I_ub;
                    lb_n_next      = ~I_lb;
                    cnt_next       = WAIT_INIT;
                    if (I_we) begin
                        sram_data_oe_next = 1'b1;
                        state_next        = WSETUP;
                    end else begin
                        oe_n_next  = 1'b0;
                        state_next = READ;
                    end
                end
            end

            READ: begin
                if (cnt != 4'h0) begin
                    cnt_next = cnt - 4'h1;
                end else begin
                    data_next  = I_sram_data;
                    ack_next   = tag;
                    ce_n_next  = 1'b1;
                    oe_n_next  = 1'b1;
                    ub_n_next  = 1'b1;
                    lb_n_next  = 1'b1;
                    state_next = IDLE;
                end
            end

            // Address and data have had one full cycle to settle before we_n falls.
            WSETUP: begin
                we_n_next  = 1'b0;
                cnt_next   = WAIT_INIT;
                state_next = WRITE;
            end

            WRITE: begin
                if (cnt != 4'h0) begin
                    cnt_next = cnt - 4'h1;
                end else begin
                    we_n_next  = 1'b1;
                    state_next = WHOLD;
                end
            end

            WHOLD: begin
                ack_next          = tag;
                ce_n_next         = 1'b1;
                ub_n_next         = 1'b1;
                lb_n_next         = 1'b1;
                sram_data_oe_next = 1'b0;
                state_next        = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Reset drops any access in flight, including its tag, and parks the pins inactive.
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state          <= IDLE;
            cnt            <= 4'h0;
            tag            <= 4'h0;
            O_data         <= 16'h0000;
            O_ack          <= 4'h0;
            O_sram_addr    <= '0;
            O_sram_data    <= 16'h0000;
            O_sram_data_oe <= 1'b0;
            O_sram_ce_n    <= 1'b1;
            O_sram_oe_n    <= 1'b1;
            O_sram_we_n    <= 1'b1;
            O_sram_ub_n    <= 1'b1;
            O_sram_lb_n    <= 1'b1;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            tag            <= tag_next;
            O_data         <= data_next;
            O_ack          <= ack_next;
            O_sram_addr    <= sram_addr_next;
            O_sram_data    <= sram_data_next;
            O_sram_data_oe <= sram_data_oe_next;
            O_sram_ce_n    <= ce_n_next;
            O_sram_oe_n    <= oe_n_next;
            O_sram_we_n    <= we_n_next;
            O_sram_ub_n    <= ub_n_next;
            O_sram_lb_n    <= lb_n_next;
        end
    end

endmodule

// File: tb/tb_spu32_sram16_ctrl.sv
// Bench for spu32_sram16_ctrl: three instances (WAIT_CYCLES 1, 0, 3), each attached to a
// behavioural SRAM that commits a write when we_n rises while ce_n is still low.
module tb_spu32_sram16_ctrl;

    localparam int NUM_INST = 3;
    localparam int NUM_VECS = 24;
    localparam int MEM_WORDS = 262144;

    logic        clk;
    logic        rst       [NUM_INST];
    logic [3:0]  req       [NUM_INST];
    logic        we        [NUM_INST];
    logic        ub        [NUM_INST];
    logic        lb        [NUM_INST];
    logic [17:0] addr      [NUM_INST];
    logic [15:0] wdata     [NUM_INST];
    logic [15:0] rdata     [NUM_INST];
    logic [3:0]  ack       [NUM_INST];
    logic        stall     [NUM_INST];
    logic [17:0] sram_addr [NUM_INST];
    logic [15:0] sram_dout [NUM_INST];
    logic        sram_oe   [NUM_INST];
    logic [15:0] sram_din  [NUM_INST];
    logic        ce_n      [NUM_INST];
    logic        oe_n      [NUM_INST];
    logic        we_n      [NUM_INST];
    logic        ub_n      [NUM_INST];
    logic        lb_n      [NUM_INST];

    int tests_run = 0;
    int tests_failed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NUM_INST; g++) begin : g_dut
        localparam int W = (g == 0) ? 1 : ((g == 1) ? 0 : 3);

        spu32_sram16_ctrl #(
            .ADDR_BITS  (18),
            .WAIT_CYCLES(W)
        ) dut (
            .I_clk         (clk),
            .I_reset       (rst[g]),
            .I_request     (req[g]),
            .I_we          (we[g]),
            .I_ub          (ub[g]),
            .I_lb          (lb[g]),
            .I_addr        (addr[g]),
            .I_data        (wdata[g]),
            .O_data        (rdata[g]),
            .O_ack         (ack[g]),
            .O_stall       (stall[g]),
            .O_sram_addr   (sram_addr[g]),
            .O_sram_data   (sram_dout[g]),
            .O_sram_data_oe(sram_oe[g]),
            .I_sram_data   (sram_din[g]),
            .O_sram_ce_n   (ce_n[g]),
            .O_sram_oe_n   (oe_n[g]),
            .O_sram_we_n   (we_n[g]),
            .O_sram_ub_n   (ub_n[g]),
            .O_sram_lb_n   (lb_n[g])
        );

        logic [15:0] mem [MEM_WORDS];
        logic        prev_we_n;

        initial begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] = 16'h5A5A;
        end

        // Pins are sampled mid-cycle so the model never races the controller's edge.
        always @(negedge clk) begin
            if (prev_we_n == 1'b0 && we_n[g] && !ce_n[g] && sram_oe[g]) begin
                if (!ub_n[g]) mem[sram_addr[g]][15:8] <= sram_dout[g][15:8];
                if (!lb_n[g]) mem[sram_addr[g]][7:0]  <= sram_dout[g][7:0];
            end
            prev_we_n <= we_n[g];
        end

        assign sram_din[g] = (!ce_n[g] && !oe_n[g]) ? mem[sram_addr[g]] : 16'hDEAD;
    end

    typedef struct {
        int          inst;
        logic        we;
        logic [3:0]  tag;
        logic        ub;
        logic        lb;
        logic [17:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        int          exp_lat;
        int          exp_low;
    } vec_t;

    vec_t vecs [NUM_VECS];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issues one request to an idle instance and follows it to its ack, recording strobe width and lanes.
    task automatic applyStimulus(
        input  int          inst,
        input  logic        w,
        input  logic [3:0]  tag,
        input  logic        u,
        input  logic        l,
        input  logic [17:0] a,
        input  logic [15:0] d,
        output int          lat,
        output logic [3:0]  got_tag,
        output logic [15:0] got_data,
        output int          low_cnt,
        output logic [1:0]  lanes
    );
        lat      = 999;
        got_tag  = 4'h0;
        got_data = 16'h0000;
        low_cnt  = 0;
        lanes    = 2'b11;
        checkOutput($sformatf("inst%0d_idle_stall", inst), 32'(stall[inst]), 32'd0);
        req[inst]   = tag;
        we[inst]    = w;
        ub[inst]    = u;
        lb[inst]    = l;
        addr[inst]  = a;
        wdata[inst] = d;
        @(posedge clk); #1;
        req[inst]   = 4'h0;
        we[inst]    = ~w;
        ub[inst]    = ~u;
        lb[inst]    = ~l;
        addr[inst]  = ~a;
        wdata[inst] = ~d;
        checkOutput($sformatf("inst%0d_ack_pulse", inst), 32'(ack[inst]), 32'd0);
        checkOutput($sformatf("inst%0d_pin_addr", inst), 32'(sram_addr[inst]), 32'(a));
        for (int n = 0; n < 40 && lat == 999; n++) begin
            if (n > 0) begin
                @(posedge clk); #1;
            end
            if (w ? !we_n[inst] : !oe_n[inst]) begin
                low_cnt++;
                lanes = {ub_n[inst], lb_n[inst]};
            end
            if (ack[inst] != 4'h0) begin
                lat      = n;
                got_tag  = ack[inst];
                got_data = rdata[inst];
            end
        end
    endtask

    int          lat;
    int          low_cnt;
    logic [3:0]  got_tag;
    logic [15:0] got_data;
    logic [1:0]  lanes;
    int          n_acks;
    int          t1, t2;
    logic [3:0]  tag1, tag2;
    logic [15:0] d1, d2;
    logic        accept_next;
    int          stray;

    initial begin
        //          inst we    tag    ub    lb    addr       wdata     rdata     lat low
        vecs[0]  = '{0, 1'b1, 4'h1, 1'b1, 1'b1, 18'h00010, 16'h3210, 16'h0000, 4, 2};
        vecs[1]  = '{0, 1'b0, 4'h2, 1'b1, 1'b1, 18'h00010, 16'h0000, 16'h3210, 2, 2};
        vecs[2]  = '{0, 1'b1, 4'h3, 1'b0, 1'b1, 18'h3FFFF, 16'hAABB, 16'h0000, 4, 2};
        vecs[3]  = '{0, 1'b0, 4'h4, 1'b1, 1'b1, 18'h3FFFF, 16'h0000, 16'h5ABB, 2, 2};
        vecs[4]  = '{0, 1'b1, 4'h6, 1'b0, 1'b0, 18'h00020, 16'h1234, 16'h0000, 4, 2};
        vecs[5]  = '{0, 1'b0, 4'h7, 1'b1, 1'b1, 18'h00020, 16'h0000, 16'h5A5A, 2, 2};
        vecs[6]  = '{0, 1'b1, 4'h8, 1'b1, 1'b0, 18'h00021, 16'hCC00, 16'h0000, 4, 2};
        vecs[7]  = '{0, 1'b0, 4'hC, 1'b1, 1'b1, 18'h00021, 16'h0000, 16'hCC5A, 2, 2};
        vecs[8]  = '{1, 1'b1, 4'h1, 1'b1, 1'b1, 18'h00100, 16'h1111, 16'h0000, 3, 1};
        vecs[9]  = '{1, 1'b0, 4'h2, 1'b1, 1'b1, 18'h00100, 16'h0000, 16'h1111, 1, 1};
        vecs[10] = '{1, 1'b1, 4'h3, 1'b0, 1'b1, 18'h00101, 16'hBEEF, 16'h0000, 3, 1};
        vecs[11] = '{1, 1'b0, 4'h4, 1'b1, 1'b1, 18'h00101, 16'h0000, 16'h5AEF, 1, 1};
        vecs[12] = '{1, 1'b1, 4'h5, 1'b1, 1'b1, 18'h20000, 16'h0F0F, 16'h0000, 3, 1};
        vecs[13] = '{1, 1'b0, 4'h6, 1'b1, 1'b1, 18'h20000, 16'h0000, 16'h0F0F, 1, 1};
        vecs[14] = '{1, 1'b1, 4'h7, 1'b1, 1'b1, 18'h3FFFE, 16'h8001, 16'h0000, 3, 1};
        vecs[15] = '{1, 1'b0, 4'h8, 1'b1, 1'b1, 18'h3FFFE, 16'h0000, 16'h8001, 1, 1};
        vecs[16] = '{2, 1'b1, 4'h1, 1'b1, 1'b1, 18'h00200, 16'h2222, 16'h0000, 6, 4};
        vecs[17] = '{2, 1'b0, 4'h2, 1'b1, 1'b1, 18'h00200, 16'h0000, 16'h2222, 4, 4};
        vecs[18] = '{2, 1'b1, 4'h3, 1'b1, 1'b0, 18'h00201, 16'h9876, 16'h0000, 6, 4};
        vecs[19] = '{2, 1'b0, 4'h4, 1'b1, 1'b1, 18'h00201, 16'h0000, 16'h985A, 4, 4};
        vecs[20] = '{2, 1'b1, 4'h5, 1'b1, 1'b1, 18'h3FFFF, 16'hFFFF, 16'h0000, 6, 4};
        vecs[21] = '{2, 1'b0, 4'h6, 1'b1, 1'b1, 18'h3FFFF, 16'h0000, 16'hFFFF, 4, 4};
        vecs[22] = '{2, 1'b1, 4'hF, 1'b1, 1'b1, 18'h00000, 16'h0001, 16'h0000, 6, 4};
        vecs[23] = '{2, 1'b0, 4'hE, 1'b1, 1'b1, 18'h00000, 16'h0000, 16'h0001, 4, 4};

        for (int i = 0; i < NUM_INST; i++) begin
            rst[i]   = 1'b1;
            req[i]   = 4'h3;
            we[i]    = 1'b0;
            ub[i]    = 1'b1;
            lb[i]    = 1'b1;
            addr[i]  = 18'h00005;
            wdata[i] = 16'h0000;
        end

        // Two reset edges with a request pending: nothing may be accepted.
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NUM_INST; i++) begin
                checkOutput($sformatf("rst%0d_inst%0d_stall", c, i), 32'(stall[i]), 32'd1);
                checkOutput($sformatf("rst%0d_inst%0d_ack", c, i), 32'(ack[i]), 32'd0);
                checkOutput($sformatf("rst%0d_inst%0d_pins_n", c, i),
                            32'({ce_n[i], oe_n[i], we_n[i], ub_n[i], lb_n[i]}), 32'h1F);
                checkOutput($sformatf("rst%0d_inst%0d_data_oe", c, i), 32'(sram_oe[i]), 32'd0);
            end
        end
        for (int i = 0; i < NUM_INST; i++) begin
            rst[i] = 1'b0;
            req[i] = 4'h0;
        end
        @(posedge clk); #1;
        for (int i = 0; i < NUM_INST; i++) begin
            checkOutput($sformatf("post_rst_inst%0d_ce_n", i), 32'(ce_n[i]), 32'd1);
            checkOutput($sformatf("post_rst_inst%0d_stall", i), 32'(stall[i]), 32'd0);
        end

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i].inst, vecs[i].we, vecs[i].tag, vecs[i].ub, vecs[i].lb,
                          vecs[i].addr, vecs[i].wdata, lat, got_tag, got_data, low_cnt, lanes);
            checkOutput($sformatf("vec%0d_tag", i), 32'(got_tag), 32'(vecs[i].tag));
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            checkOutput($sformatf("vec%0d_strobe_len", i), 32'(low_cnt), 32'(vecs[i].exp_low));
            checkOutput($sformatf("vec%0d_lanes_n", i), 32'(lanes), 32'({~vecs[i].ub, ~vecs[i].lb}));
            if (!vecs[i].we) begin
                checkOutput($sformatf("vec%0d_rdata", i), 32'(got_data), 32'(vecs[i].exp_rdata));
            end
        end

        // Tag hold: a second request appears while stalled and must wait for the first ack.
        req[0]  = 4'h5;
        we[0]   = 1'b0;
        ub[0]   = 1'b1;
        lb[0]   = 1'b1;
        addr[0] = 18'h00010;
        @(posedge clk); #1;
        checkOutput("hold_stall", 32'(stall[0]), 32'd1);
        req[0]  = 4'h9;
        addr[0] = 18'h00020;
        n_acks = 0;
        t1 = 0; t2 = 0; tag1 = 4'h0; tag2 = 4'h0; d1 = 16'h0; d2 = 16'h0;
        accept_next = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            if (accept_next) begin
                req[0] = 4'h0;
                accept_next = 1'b0;
            end
            if (ack[0] != 4'h0) begin
                if (n_acks == 0) begin
                    t1 = n; tag1 = ack[0]; d1 = rdata[0];
                end else begin
                    t2 = n; tag2 = ack[0]; d2 = rdata[0];
                end
                n_acks++;
            end
            if (req[0] == 4'h9 && stall[0] == 1'b0) accept_next = 1'b1;
        end
        checkOutput("hold_ack_count", 32'(n_acks), 32'd2);
        checkOutput("hold_first_tag", 32'(tag1), 32'h5);
        checkOutput("hold_first_time", 32'(t1), 32'd2);
        checkOutput("hold_first_data", 32'(d1), 32'h3210);
        checkOutput("hold_second_tag", 32'(tag2), 32'h9);
        checkOutput("hold_second_time", 32'(t2), 32'd5);
        checkOutput("hold_second_data", 32'(d2), 32'h5A5A);

        // Reset while we_n is low: the write is abandoned and never acknowledged.
        req[0]   = 4'hA;
        we[0]    = 1'b1;
        ub[0]    = 1'b1;
        lb[0]    = 1'b1;
        addr[0]  = 18'h00030;
        wdata[0] = 16'h7777;
        @(posedge clk); #1;
        req[0] = 4'h0;
        @(posedge clk); #1;
        checkOutput("rstw_we_low", 32'(we_n[0]), 32'd0);
        rst[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        checkOutput("rstw_we_n", 32'(we_n[0]), 32'd1);
        checkOutput("rstw_ce_n", 32'(ce_n[0]), 32'd1);
        checkOutput("rstw_data_oe", 32'(sram_oe[0]), 32'd0);
        checkOutput("rstw_ack", 32'(ack[0]), 32'd0);
        stray = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (ack[0] != 4'h0) stray++;
        end
        checkOutput("rstw_no_ack", 32'(stray), 32'd0);
        applyStimulus(0, 1'b0, 4'hB, 1'b1, 1'b1, 18'h00030, 16'h0000,
                      lat, got_tag, got_data, low_cnt, lanes);
        checkOutput("rstw_read_tag", 32'(got_tag), 32'hB);
        checkOutput("rstw_read_latency", 32'(lat), 32'd2);
        checkOutput("rstw_read_data", 32'(got_data), 32'h5A5A);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/spu32_sram16_ctrl.md
# spu32_sram16_ctrl

Physical-side controller for an external asynchronous 16-bit SRAM. It sits directly downstream of the 32-bit-to-16-bit memory bus adapter. It consumes the adapter's tagged 16-bit request stream (request tag, we, ub/lb, address, data) and drives the SRAM chip pins with programmable access timing. It returns read data together with a one-cycle tagged acknowledge, and applies stall while an access is in flight.

## Interface
- ADDR_BITS, 18, SRAM word-address width
- WAIT_CYCLES, 1, extra cycles OE_n/WE_n stay low beyond the minimum of one (range 0..15)

- I_clk  in  1  system clock, all logic on rising edge
- I_reset  in  1  synchronous, active-high reset
- I_request  in  4  request tag; nonzero = request present, 0 = no request
- I_we  in  1  1 = write, 0 = read
- I_ub  in  1  upper byte lane enable (bits 15:8)
- I_lb  in  1  lower byte lane enable (bits 7:0)
- I_addr  in  ADDR_BITS  word address
- I_data  in  16  write data
- O_data  out  16  read data, valid while O_ack != 0, held until next read completes
- O_ack  out  4  one-cycle pulse carrying the tag of the completed access
- O_stall  out  1  1 = request not accepted this cycle
- O_sram_addr  out  ADDR_BITS  SRAM address pins
- O_sram_data  out  16  SRAM write data (tristate driven externally by O_sram_data_oe)
- O_sram_data_oe  out  1  1 = controller drives data pins
- I_sram_data  in  16  SRAM data pins input
- O_sram_ce_n, O_sram_oe_n, O_sram_we_n, O_sram_ub_n, O_sram_lb_n  out  1 each  active-low chip controls

## Operation
- States: IDLE, READ, WSETUP, WRITE, WHOLD.
- O_stall = I_reset | (state != IDLE). Combinational.
- Accept: the request is accepted at a rising edge when state == IDLE, I_reset == 0 and I_request != 0. On acceptance, latch the tag, address, data, we, ub and lb. Set ce_n=0, ub_n=!I_ub, lb_n=!I_lb and cnt=WAIT_CYCLES.
- Read accept: oe_n=0, state -> READ.
- READ: if cnt != 0, decrement cnt. If cnt == 0, capture I_sram_data into O_data, set O_ack=tag, set ce_n/oe_n/ub_n/lb_n=1 and go to IDLE.
- Write accept: data_oe=1, O_sram_data=I_data, we_n stays 1, state -> WSETUP (address setup cycle).
- WSETUP: we_n=0, cnt=WAIT_CYCLES, state -> WRITE.
- WRITE: if cnt != 0, decrement cnt. If cnt == 0, set we_n=1 and go to WHOLD. Address and data are held.
- WHOLD: set O_ack=tag, ce_n=1, ub_n=lb_n=1, data_oe=0, state -> IDLE.
- O_ack is 0 in every cycle except the completion cycle.
- Byte lanes: ub/lb pass through unchanged. A request with both lanes disabled still runs a full cycle and is acknowledged. On reads, O_data captures all 16 bits regardless of lane enables.
- I_request changing while O_stall=1 is ignored. The latched copy is authoritative.

## Timing
- Reset values (the edge with I_reset=1): state=IDLE, O_ack=0, O_data=0, ce_n=oe_n=we_n=ub_n=lb_n=1, data_oe=0, O_sram_addr=0, O_sram_data=0, cnt=0.
- Reset mid-access aborts the access at that edge: all pins are deasserted, no ack is issued and the tag is dropped.
- Read latency: accepted at edge k, O_ack/O_data are valid from edge k+WAIT_CYCLES+1 for exactly one cycle. oe_n is low for WAIT_CYCLES+1 cycles.
- Write latency: accepted at edge k, we_n is low from edge k+1 for WAIT_CYCLES+1 cycles, we_n rises at k+WAIT_CYCLES+2, and O_ack is valid from edge k+WAIT_CYCLES+3. Address and data are stable one cycle before and one cycle after the we_n low window.
- Back-to-back: O_stall drops in the ack cycle, so the next request is accepted at the edge ending the ack cycle. ce_n therefore goes high for at least one cycle between accesses.
- Throughput: one read per WAIT_CYCLES+2 cycles, one write per WAIT_CYCLES+4 cycles.

## Test plan
- Reset: hold I_reset for 2 cycles with I_request=4'h3 -> O_stall=1, no acceptance, O_ack=0, all *_n=1, data_oe=0.
- Write then read, WAIT_CYCLES=1: write tag 4'h1, addr 0x00010, data 0x3210, ub=lb=1. Required: we_n low for exactly 2 cycles, O_ack=4'h1 at k+4. Then read tag 4'h2 at the same address -> O_ack=4'h2 and O_data=0x3210 at k+2.
- Byte lanes: write 0xAABB with lb only to addr 0x3FFFF (top address, tests address width), then read -> behavioural SRAM model returns 0x??BB with the upper byte unchanged; ub_n=1 and lb_n=0 during the write.
- Stall/tag hold: present read tag 4'h5, then change I_request to 4'h9 and I_addr while O_stall=1 -> exactly one ack carrying 4'h5. The 4'h9 request is accepted only after the ack cycle.
- Reset mid-write: assert I_reset during WRITE -> we_n=1, ce_n=1 and data_oe=0 at that edge, no O_ack ever for that tag, and the next read returns the old memory contents.
- WAIT_CYCLES=0 and 3 sweep: 8 alternating writes/reads -> read latency 1 and 4, write latency 3 and 6, all data matches.
